// File: rtl/mcu_bus_bridge.sv
// MCU async SRAM-style bus to FPGA clock-domain bridge.
// Synchronises pin strobes and issues one-cycle peripheral strobes.
module mcu_bus_bridge #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PERIP   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ncs,
  input  logic                  nwe,
  input  logic                  nrd,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_oe,
  output logic [ADDR_WIDTH-4:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [NUM_PERIP-1:0]  per_sel,
  output logic                  bus_we,
  output logic                  bus_rd,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [7:0]            err_cnt
);

  localparam int LW = ADDR_WIDTH - 3;
  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_WAIT,
    S_RD_DRIVE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [SYNC_STAGES-1:0] r_ncs_q;
  logic [SYNC_STAGES-1:0] r_nwe_q;
  logic [SYNC_STAGES-1:0] r_nrd_q;
  logic [ADDR_WIDTH-1:0]  r_addr_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]  r_data_q [SYNC_STAGES];

  logic [DATA_WIDTH-1:0]  r_data_o;
  logic [LW-1:0]          r_bus_addr;
  logic [DATA_WIDTH-1:0]  r_bus_wdata;
  logic [NUM_PERIP-1:0]   r_per_sel;
  logic                   r_bus_we;
  logic                   r_bus_rd;
  logic [7:0]             r_err_cnt;
  logic [2:0]             r_lat_cnt;

  logic                   w_cs_s;
  logic                   w_we_s;
  logic                   w_rd_s;
  logic [ADDR_WIDTH-1:0]  w_addr_s;
  logic [DATA_WIDTH-1:0]  w_data_s;
  logic [NUM_PERIP-1:0]   w_sel;

  logic w_latch_wr;
  logic w_latch_rd;
  logic w_we_go;
  logic w_rd_go;
  logic w_cap;
  logic w_err_go;

  // Address/data ride the same depth as the strobes to stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ncs_q <= '1;
      r_nwe_q <= '1;
      r_nrd_q <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_addr_q[i] <= '0;
        r_data_q[i] <= '0;
      end
    end else begin
      r_ncs_q <= {r_ncs_q[SYNC_STAGES-2:0], ncs};
      r_nwe_q <= {r_nwe_q[SYNC_STAGES-2:0], nwe};
      r_nrd_q <= {r_nrd_q[SYNC_STAGES-2:0], nrd};
      r_addr_q[0] <= address;
      r_data_q[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_addr_q[i] <= r_addr_q[i-1];
        r_data_q[i] <= r_data_q[i-1];
      end
    end
  end

  assign w_cs_s   = ~r_ncs_q[SYNC_STAGES-1];
  assign w_we_s   = ~r_nwe_q[SYNC_STAGES-1];
  assign w_rd_s   = ~r_nrd_q[SYNC_STAGES-1];
  assign w_addr_s = r_addr_q[SYNC_STAGES-1];
  assign w_data_s = r_data_q[SYNC_STAGES-1];

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_PERIP; i++) begin
      if (w_addr_s[ADDR_WIDTH-1 -: 3] == i[2:0]) begin
        w_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_latch_wr = 1'b0;
    w_latch_rd = 1'b0;
    w_we_go    = 1'b0;
    w_rd_go    = 1'b0;
    w_cap      = 1'b0;
    w_err_go   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_s && w_we_s && w_rd_s) begin
          w_nxt    = S_ERROR;
          w_err_go = 1'b1;
        end else if (w_cs_s && w_we_s) begin
          w_nxt      = S_WRITE;
          w_latch_wr = 1'b1;
        end else if (w_cs_s && w_rd_s) begin
          w_nxt      = S_RD_WAIT;
          w_rd_go    = 1'b1;
          w_latch_rd = 1'b1;
        end
      end
      S_WRITE: begin
        if (w_rd_s) begin
          w_nxt    = S_ERROR;
          w_err_go = 1'b1;
        end else if (!w_cs_s) begin
          w_nxt = S_IDLE;
        end else if (!w_we_s) begin
          w_nxt   = S_IDLE;
          w_we_go = 1'b1;
        end else begin
          w_latch_wr = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (r_lat_cnt == LAT) begin
          w_nxt = S_RD_DRIVE;
          w_cap = 1'b1;
        end
      end
      S_RD_DRIVE: begin
        if (!w_rd_s || !w_cs_s) begin
          w_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        if (!w_cs_s && !w_we_s && !w_rd_s) begin
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_o    <= '0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_per_sel   <= '0;
      r_bus_we    <= 1'b0;
      r_bus_rd    <= 1'b0;
      r_err_cnt   <= '0;
      r_lat_cnt   <= '0;
    end else begin
      r_bus_we <= w_we_go;
      r_bus_rd <= w_rd_go;
      if (w_latch_wr || w_latch_rd) begin
        r_bus_addr <= w_addr_s[LW-1:0];
        r_per_sel  <= w_sel;
      end
      if (w_latch_wr) begin
        r_bus_wdata <= w_data_s;
      end
      if (r_state == S_RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
      end else begin
        r_lat_cnt <= '0;
      end
      // Unmapped selects read back as zero rather than bus noise.
      if (w_cap) begin
        r_data_o <= (|r_per_sel) ? bus_rdata : '0;
      end
      if (w_err_go && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign data_o    = r_data_o;
  assign data_oe   = (r_state == S_RD_WAIT) || (r_state == S_RD_DRIVE);
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign per_sel   = r_per_sel;
  assign bus_we    = r_bus_we;
  assign bus_rd    = r_bus_rd;
  assign err_cnt   = r_err_cnt;

endmodule

// File: doc/mcu_bus_bridge.md
# mcu_bus_bridge

Bridges the MCU's asynchronous SRAM-style parallel bus (ncs/nwe/nrd, 14-bit address, 8-bit data) into the FPGA clock domain. It sits directly upstream of the peripheral array inside `system` (encoder, motor and other peripherals). Pin strobes are synchronised, and the block emits one-cycle write/read strobes with a one-hot peripheral select. It captures read data and presents it to the top-level tristate data pad.

## Interface
- `ADDR_WIDTH`, 14: MCU address width; top 3 bits select the peripheral, the low `ADDR_WIDTH-3` bits are the local address.
- `DATA_WIDTH`, 8: data bus width.
- `NUM_PERIP`, 8: number of peripheral selects (1..8).
- `SYNC_STAGES`, 2: synchroniser depth for strobes, address and data (≥2).
- `RD_LATENCY`, 1: clocks from `bus_rd` to valid `bus_rdata` (1..4).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `ncs`, `nwe`, `nrd`  in  1 each  MCU strobes, active-low, asynchronous to `clk`.
- `address`  in  ADDR_WIDTH  MCU address pins.
- `data_i`  in  DATA_WIDTH  pad input side of `data_bus`.
- `data_o`  out  DATA_WIDTH  pad output side of `data_bus`.
- `data_oe`  out  1  pad output enable; the top drives `data_bus` when this is high.
- `bus_addr`  out  ADDR_WIDTH-3  latched local address.
- `bus_wdata`  out  DATA_WIDTH  latched write data.
- `per_sel`  out  NUM_PERIP  one-hot peripheral select, valid with strobes.
- `bus_we`  out  1  single-cycle write strobe.
- `bus_rd`  out  1  single-cycle read strobe.
- `bus_rdata`  in  DATA_WIDTH  ORed peripheral read data.
- `err_cnt`  out  8  saturating protocol-error count.

## Operation
- **Synchronisation.** `ncs`, `nwe` and `nrd` pass through SYNC_STAGES flops, all reset to 1. `address` and `data_i` pass through the same depth so they stay aligned with the strobes. The names `cs_s`, `we_s` and `rd_s` denote the synchronised, inverted (active-high) strobes.
- **Decode.** `per_sel[i]` = 1 when `addr_s[ADDR_WIDTH-1:ADDR_WIDTH-3] == i`. For i ≥ NUM_PERIP, `per_sel` is all-zero: writes are dropped and reads return 0.
- **IDLE.**
  - `cs_s & we_s & ~rd_s` → WRITE.
  - `cs_s & rd_s & ~we_s` → READ_WAIT, with `bus_rd` pulsed this cycle and `bus_addr`/`per_sel` latched.
  - `cs_s & we_s & rd_s` → ERROR.
- **WRITE.** `bus_addr`, `bus_wdata` and `per_sel` update every cycle from the synchronised pins.
  - When `we_s` falls with `cs_s` still high: pulse `bus_we` for one cycle using the last latched values, then go to IDLE.
  - When `cs_s` falls first: abort, no `bus_we`, go to IDLE.
  - When `rd_s` rises: go to ERROR.
- **READ_WAIT.** Count RD_LATENCY cycles, then capture `bus_rdata` into `data_o` (0x00 if `per_sel` is zero) and go to READ_DRIVE.
- **READ_DRIVE.** Hold `data_o`. Go to IDLE when `rd_s` or `cs_s` falls.
- **ERROR.** Increment `err_cnt` once (saturating at 255). No strobes are issued and `data_oe` stays 0. Stay in ERROR until `cs_s`, `we_s` and `rd_s` are all 0, then go to IDLE.
- **Output enable.** `data_oe` = 1 in READ_WAIT and READ_DRIVE, 0 in all other states. During READ_WAIT, `data_o` shows the previous read value.
- **Per-strobe limits.** At most one `bus_we` or `bus_rd` is issued per MCU strobe assertion.

## Timing
- **Reset.**
  - Any time `reset` = 0: state IDLE; `data_o` = 0, `data_oe` = 0, `bus_we` = 0, `bus_rd` = 0, `bus_addr` = 0, `bus_wdata` = 0, `per_sel` = 0, `err_cnt` = 0; synchroniser flops set to 1.
  - Reset mid-transaction drops the transaction silently.
- **Write.** `bus_we` goes high SYNC_STAGES+1 clocks after the `nwe` pin rises. Data/address are the values present SYNC_STAGES+1 clocks before that edge.
- **Read.**
  - `bus_rd` and the `data_oe` rise occur SYNC_STAGES+1 clocks after the `nrd` pin falls.
  - `data_o` becomes valid RD_LATENCY+1 clocks after `bus_rd`.
  - `data_oe` falls SYNC_STAGES+1 clocks after the `nrd` or `ncs` pin rises.
- **MCU strobe requirements.** Low time ≥ SYNC_STAGES+RD_LATENCY+3 clocks (6 at default = 62.5 ns at 96 MHz). High time between accesses ≥ SYNC_STAGES+2 clocks.
- **Back-to-back accesses.** A new strobe detected in the same cycle the state returns to IDLE is accepted on the next cycle; it is never lost.

## Test plan
- **Reset values.** Hold `reset`=0 with pins toggling → all outputs 0. Release `reset` → no strobe is issued until a valid access occurs.
- **Write.** Write address 0x0805 / data 0xA5 with an 8-clock `nwe` low → exactly one `bus_we` pulse with `per_sel`=8'b0000_0010, `bus_addr`=0x005, `bus_wdata`=0xA5, at SYNC_STAGES+1 clocks after `nwe` rises.
- **Read.** Read address 0x3001 with `bus_rdata`=0x3C and an 8-clock `nrd` low → `bus_rd` pulse with `per_sel`=8'b0100_0000. `data_o`=0x3C within 2 clocks. `data_oe` high from bus_rd cycle until 3 clocks after `nrd` rises.
- **Aborted write.** `ncs` rises while `nwe` is still low → no `bus_we`, state IDLE, `err_cnt` unchanged.
- **Protocol error.** Assert `nwe` and `nrd` together with `ncs` low → `err_cnt` increments by 1, no strobes, `data_oe`=0. After 256 such errors `err_cnt` reads 255.
- **Out-of-range select.** With NUM_PERIP=4, read address 0x2000 → `per_sel`=0, `data_o`=0x00. Write address 0x2000 → no `per_sel` bit set.
